// File: rtl/gate_tt_checker.sv
// gate_tt_checker: walks a two-input gate through its four input vectors,
// samples Z after a settle window and scores it against a truth table.
module gate_tt_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECTED      = 4'b0110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] first_fail
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned ERR_W = 3;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [3:0]         mask_q, mask_d;
    logic [IDX_W-1:0]   ff_q, ff_d;

    logic               sample_c;
    logic               mism_c;

    // Sample strobe on the last settle cycle; X/Z on Z scores as a mismatch.
    assign sample_c = (state_q == S_RUN) && (cnt_q == CNT_W'(1));
    assign mism_c   = (Z !== EXPECTED[idx_q]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (sample_c && (idx_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the vector index, settle counter and result registers.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        err_d  = err_q;
        mask_d = mask_q;
        ff_d   = ff_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    cnt_d  = RELOAD;
                    busy_d = 1'b1;
                    pass_d = 1'b0;
                    err_d  = '0;
                    mask_d = '0;
                    ff_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (sample_c) begin
                    if (mism_c) begin
                        mask_d[idx_q] = 1'b1;
                        err_d         = err_q + ERR_W'(1);
                        if (err_q == '0) ff_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (err_d == '0);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = RELOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            mask_q <= '0;
            ff_q   <= '0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            mask_q <= mask_d;
            ff_q   <= ff_d;
        end
    end

    assign A          = idx_q[1];
    assign B          = idx_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_mask  = mask_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: directed sweeps against modelled gates, results
// scored through per-instance expectation queues drained on done.
module tb_gate_tt_checker;

    localparam int M_XOR  = 0;
    localparam int M_ZERO = 1;
    localparam int M_XNOR = 2;
    localparam int M_OR   = 3;
    localparam int M_AND  = 4;

    typedef struct packed {
        logic        pass;
        logic [2:0]  err;
        logic [3:0]  mask;
        logic [1:0]  ff;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start4, start1;
    logic A4, B4, Z4, busy4, done4, pass4;
    logic A1, B1, Z1, busy1, done1, pass1;
    logic [2:0] err4, err1;
    logic [3:0] mask4, mask1;
    logic [1:0] ff4, ff1;
    int mode4 = M_XOR;
    int mode1 = M_XOR;
    int unsigned cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t q4[$];
    exp_t q1[$];

    gate_tt_checker #(.SETTLE_CYCLES(4), .EXPECTED(4'b0110)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4), .Z(Z4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_mask(mask4), .first_fail(ff4)
    );

    gate_tt_checker #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1), .Z(Z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_mask(mask1), .first_fail(ff1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            M_XOR:   return a ^ b;
            M_ZERO:  return 1'b0;
            M_XNOR:  return ~(a ^ b);
            M_OR:    return a | b;
            M_AND:   return a & b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb Z4 = gate(mode4, A4, B4);
    always_comb Z1 = gate(mode1, A1, B1);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_res(input string tag, input exp_t e, input logic p,
                           input logic [2:0] er, input logic [3:0] m, input logic [1:0] f);
        chk({tag, "_done_cycle"}, int'(cyc), int'(e.cyc));
        chk({tag, "_pass"}, int'(p), int'(e.pass));
        chk({tag, "_err_count"}, int'(er), int'(e.err));
        chk({tag, "_fail_mask"}, int'(m), int'(e.mask));
        chk({tag, "_first_fail"}, int'(f), int'(e.ff));
    endtask

    task automatic unexpected(input string tag);
        n_chk++;
        n_fail++;
        $display("FAIL %s_unexpected_done: got done=1 expected no pending sweep (cycle %0d)", tag, cyc);
    endtask

    // Monitors: score each done pulse against the oldest pending expectation.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) unexpected("dut4");
            else cmp_res("dut4", q4.pop_front(), pass4, err4, mask4, ff4);
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) unexpected("dut1");
            else cmp_res("dut1", q1.pop_front(), pass1, err1, mask1, ff1);
        end
    end

    // Entered and left at a falling edge; drives one sweep on the selected DUT.
    task automatic run_sweep(input int sel, input int mode, input bit hold,
                             input logic ep, input logic [2:0] ee,
                             input logic [3:0] em, input logic [1:0] ef);
        int p;
        int unsigned e0;
        exp_t e;
        logic [1:0] ab;
        logic bz;
        string tag;
        p   = (sel != 0) ? 1 : 4;
        tag = (sel != 0) ? "dut1" : "dut4";
        if (sel != 0) begin mode1 = mode; start1 = 1'b1; end
        else          begin mode4 = mode; start4 = 1'b1; end
        e0 = cyc + 1;
        e.pass = ep; e.err = ee; e.mask = em; e.ff = ef;
        e.cyc  = e0 + 4 * p;
        if (sel != 0) q1.push_back(e); else q4.push_back(e);
        for (int i = 0; i < 4 * p; i++) begin
            @(negedge clk);
            ab = (sel != 0) ? {A1, B1} : {A4, B4};
            bz = (sel != 0) ? busy1 : busy4;
            chk({tag, "_ab"}, int'(ab), i / p);
            chk({tag, "_busy"}, int'(bz), 1);
            if (i == 0) begin
                chk({tag, "_cleared_err"}, int'((sel != 0) ? err1 : err4), 0);
                chk({tag, "_cleared_mask"}, int'((sel != 0) ? mask1 : mask4), 0);
                chk({tag, "_cleared_pass"}, int'((sel != 0) ? pass1 : pass4), 0);
            end
            if (!hold) begin
                if (sel != 0) start1 = (i == 1);
                else          start4 = (i == 1);
            end
        end
        @(negedge clk);
        ab = (sel != 0) ? {A1, B1} : {A4, B4};
        bz = (sel != 0) ? busy1 : busy4;
        chk({tag, "_ab_done"}, int'(ab), 0);
        chk({tag, "_busy_done"}, int'(bz), 0);
        chk({tag, "_done_high"}, int'((sel != 0) ? done1 : done4), 1);
        @(negedge clk);
        chk({tag, "_done_low"}, int'((sel != 0) ? done1 : done4), 0);
    endtask

    task automatic chk_zero4(input string tag);
        chk({tag, "_A"}, int'(A4), 0);
        chk({tag, "_B"}, int'(B4), 0);
        chk({tag, "_busy"}, int'(busy4), 0);
        chk({tag, "_done"}, int'(done4), 0);
        chk({tag, "_pass"}, int'(pass4), 0);
        chk({tag, "_err"}, int'(err4), 0);
        chk({tag, "_mask"}, int'(mask4), 0);
        chk({tag, "_ff"}, int'(ff4), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e0;
        rst_n  = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero4("reset");
        chk("reset_dut1_busy", int'(busy1), 0);
        chk("reset_dut1_ab", int'({A1, B1}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero4("idle");

        run_sweep(0, M_XOR,  0, 1'b1, 3'd0, 4'b0000, 2'd0);
        run_sweep(0, M_ZERO, 0, 1'b0, 3'd2, 4'b0110, 2'd1);
        run_sweep(0, M_XNOR, 0, 1'b0, 3'd4, 4'b1111, 2'd0);
        run_sweep(0, M_OR,   0, 1'b0, 3'd1, 4'b1000, 2'd3);
        run_sweep(0, M_AND,  0, 1'b0, 3'd3, 4'b1110, 2'd1);

        // start held high across two back-to-back sweeps
        run_sweep(0, M_ZERO, 1, 1'b0, 3'd2, 4'b0110, 2'd1);
        run_sweep(0, M_XOR,  1, 1'b1, 3'd0, 4'b0000, 2'd0);
        start4 = 1'b0;
        @(negedge clk);
        chk("held_idle_busy", int'(busy4), 0);
        chk("held_result_pass", int'(pass4), 1);

        // asynchronous reset during vector 2 of a failing sweep
        mode4  = M_ZERO;
        start4 = 1'b1;
        e0     = cyc + 1;
        @(negedge clk);
        start4 = 1'b0;
        while (cyc < e0 + 9) @(negedge clk);
        chk("pre_reset_ab", int'({A4, B4}), 2);
        chk("pre_reset_err", int'(err4), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero4("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk("in_reset_done", int'(done4), 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_busy", int'(busy4), 0);
            chk("post_reset_ab", int'({A4, B4}), 0);
            chk("post_reset_err", int'(err4), 0);
        end
        run_sweep(0, M_XOR, 0, 1'b1, 3'd0, 4'b0000, 2'd0);

        // single-cycle settle window
        run_sweep(1, M_XOR,  0, 1'b1, 3'd0, 4'b0000, 2'd0);
        run_sweep(1, M_XNOR, 0, 1'b0, 3'd4, 4'b1111, 2'd0);

        repeat (3) @(negedge clk);
        chk("dut4_pending_left", q4.size(), 0);
        chk("dut1_pending_left", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
